ack_responder: RTL and testbench

- Responder end of the single-wire req/ack handshake used by the team's request circuits.
- Samples req and waits a configurable number of cycles (the multicycle latency).
- Returns a one-cycle ack pulse, then waits for req to be released.
- Flags protocol violations and counts completed transactions, so it works as both bench partner and checker target for requesters.

---
 rtl/ack_responder_pkg.sv | 16 +
 rtl/lfsr16.sv | 18 +
 rtl/ack_responder.sv | 99 +++++++++
 tb/tb_ack_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ack_responder_pkg.sv
// Shared types and constants for the ack_responder handshake responder.
package ack_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RELEASE
    } state_t;

    localparam int          LFSR_W       = 16;
    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR, free running, reloaded with seed on reset.
module lfsr16
    import ack_responder_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] out
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out <= seed;
        else
            out <= {out[LFSR_W-2:0], ^(out & LFSR_TAPS)};
    end

endmodule

// File: rtl/ack_responder.sv
// Responder end of the req/ack handshake: delayed single-cycle ack, withdraw check, transaction count.
// Optional random ack latency enabled by defining ACK_RESPONDER_RAND_DELAY_EN.
module ack_responder
    import ack_responder_pkg::*;
#(
    parameter int                DELAY_W   = 4,
    parameter int                CNT_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               ack,
    output logic               busy,
    output logic               err_withdraw,
    output logic [CNT_W-1:0]   xact_count
);

    state_t             state;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] eff_delay;

`ifdef ACK_RESPONDER_RAND_DELAY_EN
    logic [LFSR_W-1:0] lfsr_val;
    logic              unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .out     (lfsr_val)
    );

    // cfg_delay acts as a bound mask on the random latency
    assign eff_delay      = lfsr_val[DELAY_W-1:0] & cfg_delay;
    assign unused_lfsr_hi = ^(lfsr_val >> DELAY_W);
`else
    logic unused_seed;

    assign eff_delay   = cfg_delay;
    assign unused_seed = ^LFSR_SEED;
`endif

    // cnt holds the remaining WAIT cycles so ack lands exactly D edges after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ack          <= 1'b0;
            busy         <= 1'b0;
            err_withdraw <= 1'b0;
            xact_count   <= '0;
            cnt          <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (eff_delay == '0) begin
                            state <= ACK;
                            ack   <= 1'b1;
                        end else begin
                            cnt   <= eff_delay - DELAY_W'(1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        err_withdraw <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (cnt == '0) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - DELAY_W'(1);
                    end
                end
                ACK: begin
                    state      <= RELEASE;
                    xact_count <= xact_count + CNT_W'(1);
                end
                RELEASE: begin
                    if (!req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ack_responder.sv
// Self-checking bench for ack_responder using a transaction-level timing model.
module tb_ack_responder;

    localparam int DELAY_W = 4;

    logic               clk       = 1'b0;
    logic               reset_n   = 1'b0;
    logic               req       = 1'b0;
    logic [DELAY_W-1:0] cfg_delay = '0;

    logic        ack, busy, err_withdraw;
    logic [15:0] xact_count;
    logic        ack4, busy4, err4;
    logic [3:0]  xact_count4;

    int    checks     = 0;
    int    errors     = 0;
    int    modelCount = 0;
    bit    modelErr   = 1'b0;
    string phase      = "reset";

    always #5 clk = ~clk;

    ack_responder #(.DELAY_W(DELAY_W), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .cfg_delay    (cfg_delay),
        .ack          (ack),
        .busy         (busy),
        .err_withdraw (err_withdraw),
        .xact_count   (xact_count)
    );

    ack_responder #(.DELAY_W(DELAY_W), .CNT_W(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .cfg_delay    (cfg_delay),
        .ack          (ack4),
        .busy         (busy4),
        .err_withdraw (err4),
        .xact_count   (xact_count4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s (%s): observed %0h expected %0h", tag, phase, obs, exp);
        end
    endtask

    task automatic checkAll(input int k, input bit expAck, input bit expBusy,
                            input bit expErr, input int expCount);
        checkOutput($sformatf("ack k=%0d", k),    32'(ack),          32'(expAck));
        checkOutput($sformatf("busy k=%0d", k),   32'(busy),         32'(expBusy));
        checkOutput($sformatf("err k=%0d", k),    32'(err_withdraw), 32'(expErr));
        checkOutput($sformatf("count k=%0d", k),  32'(xact_count),   32'(expCount % 65536));
        checkOutput($sformatf("ack4 k=%0d", k),   32'(ack4),         32'(expAck));
        checkOutput($sformatf("busy4 k=%0d", k),  32'(busy4),        32'(expBusy));
        checkOutput($sformatf("err4 k=%0d", k),   32'(err4),         32'(expErr));
        checkOutput($sformatf("count4 k=%0d", k), 32'(xact_count4),  32'(expCount % 16));
    endtask

    // One request of latency d; req sampled high on edges 0..h, low for the next g edges.
    // Edge k is checked at the negedge that follows it.
    task automatic applyStimulus(input int d, input int h, input int g);
        bit withdraw;
        int relEdge;
        withdraw  = (h < d);
        relEdge   = (d + 2 > h + 1) ? d + 2 : h + 1;
        req       = 1'b1;
        cfg_delay = DELAY_W'(d);
        for (int k = 0; k <= h + g; k++) begin
            @(negedge clk);
            if (withdraw) begin
                if (k == h + 1) modelErr = 1'b1;
                checkAll(k, 1'b0, k <= h, modelErr, modelCount);
            end else begin
                if (k == d + 1) modelCount++;
                checkAll(k, k == d, k < relEdge, modelErr, modelCount);
            end
            req       = (k + 1 <= h);
            cfg_delay = DELAY_W'($urandom);
        end
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        modelCount = 0;
        modelErr   = 1'b0;
        checkAll(-1, 1'b0, 1'b0, 1'b0, 0);
        req     = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int d, h, g, minGap;
        $display("[TB] ack_responder bench start");
        @(negedge clk);
        @(negedge clk);
        checkAll(-1, 1'b0, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkAll(-1, 1'b0, 1'b0, 1'b0, 0);

`ifdef ACK_RESPONDER_RAND_DELAY_EN
        begin
            bit seen [16];
            int distinct;
            int lat;
            phase = "rand latency";
            for (int i = 0; i < 16; i++) seen[i] = 1'b0;
            for (int n = 0; n < 200; n++) begin
                req       = 1'b1;
                cfg_delay = 4'b0111;
                lat       = -1;
                for (int k = 0; k < 20 && lat < 0; k++) begin
                    @(negedge clk);
                    if (ack === 1'b1) lat = k;
                end
                checkOutput("rand ack seen", 32'(lat >= 0), 32'd1);
                checkOutput("rand latency in 0..7", 32'(lat >= 0 && lat <= 7), 32'd1);
                if (lat >= 0 && lat < 16) seen[lat] = 1'b1;
                req = 1'b0;
                @(negedge clk);
                @(negedge clk);
                checkOutput("rand busy after release", 32'(busy), 32'd0);
            end
            distinct = 0;
            for (int i = 0; i < 16; i++) distinct += seen[i] ? 1 : 0;
            checkOutput("rand distinct latencies >= 4", 32'(distinct >= 4), 32'd1);
            checkOutput("rand xact_count", 32'(xact_count), 32'd200);
            checkOutput("rand err_withdraw", 32'(err_withdraw), 32'd0);
        end
`else
        phase = "delay3 held";
        applyStimulus(3, 4, 1);

        phase = "delay0 back-to-back";
        for (int n = 0; n < 10; n++) applyStimulus(0, 1, 1);
        checkOutput("b2b xact_count", 32'(xact_count), 32'd11);

        phase = "withdraw";
        applyStimulus(5, 1, 1);
        phase = "after withdraw";
        applyStimulus(2, 3, 1);
        checkOutput("err sticky", 32'(err_withdraw), 32'd1);

        phase = "slow release";
        modelErr = 1'b0;
        pulseReset();
        @(negedge clk);
        applyStimulus(2, 9, 1);

        phase = "reset mid-wait";
        applyStimulus(1, 2, 1);
        req       = 1'b1;
        cfg_delay = 4'd5;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy in wait", 32'(busy), 32'd1);
        #2;
        pulseReset();
        @(negedge clk);
        checkAll(-1, 1'b0, 1'b0, 1'b0, 0);
        phase = "full latency after reset";
        applyStimulus(5, 6, 1);

        phase = "random";
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(0, 15);
            if (d > 0 && $urandom_range(0, 4) == 0) begin
                h      = $urandom_range(0, d - 1);
                minGap = 1;
            end else begin
                h      = d + $urandom_range(0, 4);
                minGap = (d + 2 - h > 1) ? d + 2 - h : 1;
            end
            g = minGap + $urandom_range(0, 3);
            applyStimulus(d, h, g);
        end

        phase = "count wrap";
        pulseReset();
        @(negedge clk);
        for (int n = 0; n < 17; n++) applyStimulus(0, 1, 1);
        checkOutput("wrap xact_count4", 32'(xact_count4), 32'd1);
        checkOutput("wrap xact_count", 32'(xact_count), 32'd17);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
